// File: rtl/cmp_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_mon_pkg
//  Description : Shared types for consumers of the 4-bit comparator's one-hot
//                outcome: lock state enum and 2-bit outcome encoding, plus a
//                decode helper.
//  Revision    : 1.0  initial release
// ============================================================================
package cmp_mon_pkg;

  // Lock state machine states
  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // Compact encoding of one comparator sample
  typedef enum logic [1:0] {
    OUT_GT  = 2'd0,
    OUT_EQ  = 2'd1,
    OUT_LT  = 2'd2,
    OUT_ILL = 2'd3
  } outcome_e;

  // Exactly one bit set is a legal outcome; anything else is illegal
  function automatic outcome_e classify(input logic g, input logic e, input logic s);
    outcome_e r;
    case ({g, e, s})
      3'b100:  r = OUT_GT;
      3'b010:  r = OUT_EQ;
      3'b001:  r = OUT_LT;
      default: r = OUT_ILL;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : W-bit up counter that sticks at its maximum value, with
//                synchronous reset and synchronous clear.
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CLR,
  input  logic         INC,
  output logic [W-1:0] Q
);

  localparam logic [W-1:0] c_MAX = {W{1'b1}};

  logic [W-1:0] r_q;

  // Count up on INC, hold at maximum; reset/clear take priority
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      r_q <= '0;
    end else if (INC && (r_q != c_MAX)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign Q = r_q;

endmodule
`default_nettype wire

// File: rtl/compare_result_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : compare_result_monitor
//  Description : Registered monitor of the comparator's one-hot outcome.
//                Keeps saturating per-outcome counters, flags non-one-hot
//                samples and runs a SEARCH/LOCKED lock state machine driven
//                by runs of consecutive EQUAL samples.
//  Revision    : 1.0  initial release
// ============================================================================
module compare_result_monitor
  import cmp_mon_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int LOCK_RUN = 4,
  parameter int MISS_MAX = 2
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            VALID_IN,
  input  logic                            GREATER,
  input  logic                            EQUAL,
  input  logic                            SMALLER,
  input  logic                            CLEAR,
  output logic [CNT_W-1:0]                GT_COUNT,
  output logic [CNT_W-1:0]                EQ_COUNT,
  output logic [CNT_W-1:0]                LT_COUNT,
  output logic [CNT_W-1:0]                ERR_COUNT,
  output logic [$clog2(LOCK_RUN+1)-1:0]   RUN_LEN,
  output logic                            LOCKED,
  output logic                            ILLEGAL
);

  localparam int c_RUN_W  = $clog2(LOCK_RUN + 1);
  localparam int c_MISS_W = $clog2(MISS_MAX + 1);

  localparam logic [c_RUN_W-1:0]  c_RUN_MAX  = c_RUN_W'(LOCK_RUN);
  localparam logic [c_MISS_W-1:0] c_MISS_MAX = c_MISS_W'(MISS_MAX);

  localparam logic [0:0] c_ST_SEARCH = cmp_mon_pkg::SEARCH;
  localparam logic [0:0] c_ST_LOCKED = cmp_mon_pkg::LOCKED;

  outcome_e              w_outcome;
  logic                  w_is_eq;
  logic                  w_is_ill;
  logic [c_RUN_W-1:0]    w_run_next;
  logic [c_MISS_W-1:0]   w_miss_inc;

  logic [0:0]            r_state;
  logic [c_RUN_W-1:0]    r_run_len;
  logic [c_MISS_W-1:0]   r_miss;
  logic                  r_illegal;

  // Decode the sample and precompute the next run length and miss count
  always_comb begin
    w_outcome  = classify(GREATER, EQUAL, SMALLER);
    w_is_eq    = (w_outcome == OUT_EQ);
    w_is_ill   = (w_outcome == OUT_ILL);
    w_run_next = (r_run_len == c_RUN_MAX) ? r_run_len : r_run_len + 1'b1;
    w_miss_inc = r_miss + 1'b1;
  end

  // Outcome statistics; CLEAR inside each counter overrides a same-cycle INC
  sat_counter #(.W(CNT_W)) u_gt_cnt (
    .CLK(CLK), .RST(RST), .CLR(CLEAR),
    .INC(VALID_IN && (w_outcome == OUT_GT)), .Q(GT_COUNT)
  );

  sat_counter #(.W(CNT_W)) u_eq_cnt (
    .CLK(CLK), .RST(RST), .CLR(CLEAR),
    .INC(VALID_IN && (w_outcome == OUT_EQ)), .Q(EQ_COUNT)
  );

  sat_counter #(.W(CNT_W)) u_lt_cnt (
    .CLK(CLK), .RST(RST), .CLR(CLEAR),
    .INC(VALID_IN && (w_outcome == OUT_LT)), .Q(LT_COUNT)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .CLK(CLK), .RST(RST), .CLR(CLEAR),
    .INC(VALID_IN && w_is_ill), .Q(ERR_COUNT)
  );

  // Lock FSM with its run-length and miss registers, plus the illegal pulse
  always_ff @(posedge CLK) begin
    if (RST || CLEAR) begin
      r_state   <= c_ST_SEARCH;
      r_run_len <= '0;
      r_miss    <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= VALID_IN && w_is_ill;
      if (VALID_IN) begin
        r_run_len <= w_is_eq ? w_run_next : '0;
        case (r_state)
          c_ST_SEARCH: begin
            r_miss <= '0;
            if (w_is_eq && (w_run_next == c_RUN_MAX)) begin
              r_state <= c_ST_LOCKED;
            end
          end
          c_ST_LOCKED: begin
            if (w_is_eq) begin
              r_miss <= '0;
            end else if (w_miss_inc == c_MISS_MAX) begin
              // Too many misses: fall back and restart the search from scratch
              r_state   <= c_ST_SEARCH;
              r_miss    <= '0;
              r_run_len <= '0;
            end else begin
              r_miss <= w_miss_inc;
            end
          end
          default: begin
            r_state <= c_ST_SEARCH;
            r_miss  <= '0;
          end
        endcase
      end
    end
  end

  assign RUN_LEN = r_run_len;
  assign LOCKED  = (r_state == c_ST_LOCKED);
  assign ILLEGAL = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_compare_result_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_compare_result_monitor
//  Description : Directed, table-driven bench for compare_result_monitor.
//                A default-width instance and a CNT_W=4 instance share the
//                same stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_compare_result_monitor;

  localparam int RW = $clog2(4 + 1);

  typedef struct {
    logic rst, clr, v, g, e, s;
    int   gt, eq, lt, err, run;
    logic lk, ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst, clr, v, g, e, s;

  logic [7:0]    gt8, eq8, lt8, err8;
  logic [RW-1:0] run8;
  logic          lk8, ill8;
  logic [3:0]    gt4, eq4, lt4, err4;
  logic [RW-1:0] run4;
  logic          lk4, ill4;

  int n_checks = 0;
  int n_errors = 0;

  vec_t vq[$];

  always #5 clk = ~clk;

  compare_result_monitor #(.CNT_W(8), .LOCK_RUN(4), .MISS_MAX(2)) dut (
    .CLK(clk), .RST(rst), .VALID_IN(v), .GREATER(g), .EQUAL(e), .SMALLER(s),
    .CLEAR(clr), .GT_COUNT(gt8), .EQ_COUNT(eq8), .LT_COUNT(lt8),
    .ERR_COUNT(err8), .RUN_LEN(run8), .LOCKED(lk8), .ILLEGAL(ill8)
  );

  compare_result_monitor #(.CNT_W(4), .LOCK_RUN(4), .MISS_MAX(2)) dut4 (
    .CLK(clk), .RST(rst), .VALID_IN(v), .GREATER(g), .EQUAL(e), .SMALLER(s),
    .CLEAR(clr), .GT_COUNT(gt4), .EQ_COUNT(eq4), .LT_COUNT(lt4),
    .ERR_COUNT(err4), .RUN_LEN(run4), .LOCKED(lk4), .ILLEGAL(ill4)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // rst clr v g e s | gt eq lt err run lk ill
  task automatic add(input logic r, input logic c, input logic vv,
                     input logic gg, input logic ee, input logic ss,
                     input int xgt, input int xeq, input int xlt, input int xerr,
                     input int xrun, input logic xlk, input logic xill);
    vec_t t;
    t = '{r, c, vv, gg, ee, ss, xgt, xeq, xlt, xerr, xrun, xlk, xill};
    vq.push_back(t);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; v = 1'b0; g = 1'b0; e = 1'b0; s = 1'b0;

    // Reset state
    add(1,0,0,0,0,0,  0,0,0,0,0,0,0);
    // Lock entry with an idle gap between the 2nd and 3rd EQUAL
    add(0,0,1,0,1,0,  0,1,0,0,1,0,0);
    add(0,0,1,0,1,0,  0,2,0,0,2,0,0);
    add(0,0,0,0,0,0,  0,2,0,0,2,0,0);
    add(0,0,1,0,1,0,  0,3,0,0,3,0,0);
    add(0,0,1,0,1,0,  0,4,0,0,4,1,0);
    // Lock hold/exit: GT (miss1), EQ (miss0), GT (miss1), LT (miss2 -> SEARCH)
    add(0,0,1,1,0,0,  1,4,0,0,0,1,0);
    add(0,0,1,0,1,0,  1,5,0,0,1,1,0);
    add(0,0,1,1,0,0,  2,5,0,0,0,1,0);
    add(0,0,1,0,0,1,  2,5,1,0,0,0,0);
    // Illegal samples 000, 110, 111 after building a short run
    add(0,0,1,0,1,0,  2,6,1,0,1,0,0);
    add(0,0,1,0,0,0,  2,6,1,1,0,0,1);
    add(0,0,1,1,1,0,  2,6,1,2,0,0,1);
    add(0,0,1,1,1,1,  2,6,1,3,0,0,1);
    add(0,0,0,0,0,0,  2,6,1,3,0,0,0);
    // CLEAR beats a simultaneous valid EQUAL
    add(0,1,1,0,1,0,  0,0,0,0,0,0,0);
    add(0,0,0,0,0,0,  0,0,0,0,0,0,0);
    // Mixed stream: 3 EQ, 1 illegal, 4 EQ
    add(0,0,1,0,1,0,  0,1,0,0,1,0,0);
    add(0,0,1,0,1,0,  0,2,0,0,2,0,0);
    add(0,0,1,0,1,0,  0,3,0,0,3,0,0);
    add(0,0,1,0,1,1,  0,3,0,1,0,0,1);
    add(0,0,1,0,1,0,  0,4,0,1,1,0,0);
    add(0,0,1,0,1,0,  0,5,0,1,2,0,0);
    add(0,0,1,0,1,0,  0,6,0,1,3,0,0);
    add(0,0,1,0,1,0,  0,7,0,1,4,1,0);
    // RST while LOCKED, then CLEAR with a valid EQUAL, then idle
    add(1,0,1,0,1,0,  0,0,0,0,0,0,0);
    add(0,1,1,0,1,0,  0,0,0,0,0,0,0);
    add(0,0,0,0,0,0,  0,0,0,0,0,0,0);

    repeat (2) @(negedge clk);

    foreach (vq[i]) begin
      rst = vq[i].rst; clr = vq[i].clr; v = vq[i].v;
      g = vq[i].g; e = vq[i].e; s = vq[i].s;
      @(negedge clk);
      chk($sformatf("v%0d gt", i),   int'(gt8),  vq[i].gt);
      chk($sformatf("v%0d eq", i),   int'(eq8),  vq[i].eq);
      chk($sformatf("v%0d lt", i),   int'(lt8),  vq[i].lt);
      chk($sformatf("v%0d err", i),  int'(err8), vq[i].err);
      chk($sformatf("v%0d run", i),  int'(run8), vq[i].run);
      chk($sformatf("v%0d lock", i), int'(lk8),  int'(vq[i].lk));
      chk($sformatf("v%0d ill", i),  int'(ill8), int'(vq[i].ill));
      chk($sformatf("v%0d gt4", i),  int'(gt4),  vq[i].gt);
      chk($sformatf("v%0d eq4", i),  int'(eq4),  vq[i].eq);
      chk($sformatf("v%0d err4", i), int'(err4), vq[i].err);
      chk($sformatf("v%0d lock4", i), int'(lk4), int'(vq[i].lk));
    end

    // Saturation: 20 SMALLER samples, the 4-bit counter sticks at 15
    rst = 1'b0; clr = 1'b0; v = 1'b1; g = 1'b0; e = 1'b0; s = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("sat%0d lt4", i), int'(lt4), (i + 1 > 15) ? 15 : i + 1);
      chk($sformatf("sat%0d lt8", i), int'(lt8), i + 1);
    end
    v = 1'b0; s = 1'b0;
    @(negedge clk);
    chk("sat hold lt4", int'(lt4), 15);
    chk("sat gt4", int'(gt4), 0);
    chk("sat eq4", int'(eq4), 0);
    chk("sat err4", int'(err4), 0);
    chk("sat run4", int'(run4), 0);
    chk("sat lock4", int'(lk4), 0);
    chk("sat ill4", int'(ill4), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/compare_result_monitor.md
# compare_result_monitor

Registered consumer of the 4-bit comparator's one-hot outcome (GREATER/EQUAL/SMALLER). It sits directly downstream of the comparator and samples its outputs when qualified by VALID_IN. It keeps saturating per-outcome statistics, flags illegal (non-one-hot) outcomes, and runs a lock state machine that declares a stable match after a run of consecutive EQUAL results. Downstream control logic reads the lock status, and software reads the counters.

## Interface
Parameters:
- CNT_W, 8: width of each outcome counter; counters saturate at 2^CNT_W-1.
- LOCK_RUN, 4: consecutive EQUAL samples required to enter LOCKED (≥1).
- MISS_MAX, 2: consecutive non-EQUAL samples tolerated in LOCKED before dropping to SEARCH (≥1).

Ports:
- CLK  in  1  single clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- VALID_IN  in  1  comparator outputs are a valid sample this cycle.
- GREATER  in  1  comparator A>B.
- EQUAL  in  1  comparator A==B.
- SMALLER  in  1  comparator A<B.
- CLEAR  in  1  synchronous clear of counters and lock state (same effect as RST).
- GT_COUNT  out  CNT_W  accepted GREATER samples.
- EQ_COUNT  out  CNT_W  accepted EQUAL samples.
- LT_COUNT  out  CNT_W  accepted SMALLER samples.
- ERR_COUNT  out  CNT_W  illegal samples.
- RUN_LEN  out  $clog2(LOCK_RUN+1)  current consecutive-EQUAL run, saturating at LOCK_RUN.
- LOCKED  out  1  lock FSM is in LOCKED.
- ILLEGAL  out  1  one-cycle pulse: the previous cycle's valid sample was not one-hot.

## Operation
- Every output is registered. On RST or CLEAR, all counters, RUN_LEN, LOCKED, ILLEGAL and the internal miss counter are 0, and the FSM is in SEARCH.
- CLEAR asserted together with VALID_IN: CLEAR wins, the sample is dropped, and no counter moves.
- Sample classification (VALID_IN=1 only): exactly one of the three outcome bits is 1 → legal; zero bits or two or more bits set → illegal. VALID_IN=0 → no state change, and ILLEGAL returns to 0.
- Legal sample: increment the matching counter, saturating (a counter at max stays at max). Illegal sample: increment ERR_COUNT only, pulse ILLEGAL.
- RUN_LEN: a legal EQUAL sample increments it (saturating at LOCK_RUN). Any other valid sample (legal non-EQUAL or illegal) clears it to 0.
- Lock FSM, states SEARCH and LOCKED:
  - SEARCH → LOCKED on the valid EQUAL sample that brings RUN_LEN to LOCK_RUN.
  - In LOCKED, a valid non-EQUAL or illegal sample increments miss. A valid EQUAL sample clears miss to 0.
  - LOCKED → SEARCH on the sample that brings miss to MISS_MAX; miss and RUN_LEN both clear to 0 on that transition.
  - An illegal sample counts as a miss in LOCKED and never advances toward lock in SEARCH.
- Gaps in VALID_IN do not break a run. Only valid samples affect RUN_LEN and miss.

## Timing
- Latency is 1 cycle. A sample presented with VALID_IN at edge N is reflected in counters, RUN_LEN, LOCKED and ILLEGAL after edge N. They are visible in cycle N+1.
- Throughput is one sample per cycle, with no backpressure. VALID_IN may be held high indefinitely.
- LOCKED rises in the cycle after the LOCK_RUN-th consecutive EQUAL sample. It falls in the cycle after the MISS_MAX-th consecutive miss.
- RST or CLEAR asserted mid-run or while LOCKED takes effect at that edge. The next cycle shows all outputs at 0.

## Structure
- Shared package `cmp_mon_pkg`: lock state enum (`SEARCH`, `LOCKED`) and a 2-bit outcome encoding (`OUT_GT`, `OUT_EQ`, `OUT_LT`, `OUT_ILL`), reused by any later consumer of comparator results.
- Sub-module `sat_counter` (parameter W; ports CLK, RST, CLR, INC, Q) is instantiated four times for the outcome counters.
- Classification is a combinational decode into the package encoding. The FSM plus the RUN_LEN and miss registers live in the top module.

## Test plan
- Reset/clear: drive samples, then RST=1 for one cycle, then CLEAR=1 with VALID_IN=1 and EQUAL=1 → all outputs 0 the next cycle, and EQ_COUNT stays 0 after the CLEAR cycle.
- Lock entry: defaults, 4 consecutive valid EQUAL with an idle cycle between the 2nd and 3rd → RUN_LEN 1,2,2,3,4, and LOCKED=1 the cycle after the 4th.
- Lock hold/exit: from LOCKED, send GT, EQ, GT, LT → LOCKED stays 1 after GT and after EQ (miss reset), stays 1 after the next GT (miss 1), then drops to 0 after LT. RUN_LEN=0 at that point.
- Illegal samples: VALID_IN=1 with {G,E,S}=000, then 110, then 111 → ERR_COUNT=3, ILLEGAL pulses each following cycle, GT/EQ/LT counts unchanged, RUN_LEN cleared.
- Saturation: CNT_W=4, 20 consecutive valid SMALLER samples → LT_COUNT reaches 15 and holds, with other counters 0.
- Mixed stream: 3 EQ, 1 ILLEGAL, 4 EQ → no lock after the first three, ERR_COUNT=1, LOCKED=1 only after the 8th sample, EQ_COUNT=7.
